wall_move_ctrl: RTL
===================

Name: wall_move_ctrl

Overview:
- Player-movement controller that sits directly downstream of the wall-map lookup.
- Once per frame it converts the current keycode into a proposed sprite position.
- It drives probe coordinates into the wall lookup, checking the four sprite corners one per cycle, and collects the returned wall bits.
- It commits the move only if no corner lands on a wall; the committed position feeds the sprite/colour-mapper stage.

Parameters:
- SPRITE_W, 16, sprite width in pixels.
- SPRITE_H, 16, sprite height in pixels.
- STEP, 2, pixels moved per accepted frame.
- START_X, 320, reset x position (top-left corner).
- START_Y, 240, reset y position (top-left corner).
- SCREEN_W, 640, visible width.
- SCREEN_H, 480, visible height.
- LOOKUP_LAT, 1, cycles from probe_x/probe_y to a valid wall_hit (registered ROM).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, from the vsync edge.
- keycode  in  8  current key: 0x1A=W(up), 0x04=A(left), 0x16=S(down), 0x07=D(right); any other value = no move.
- probe_x  out  10  x coordinate driven to the wall lookup (its DrawX input).
- probe_y  out  10  y coordinate driven to the wall lookup (its DrawY input).
- wall_hit  in  1  wall bit returned LOOKUP_LAT cycles after the probe was issued.
- pos_x  out  10  committed sprite x (top-left).
- pos_y  out  10  committed sprite y (top-left).
- busy  out  1  high while a move check is in progress.
- blocked  out  1  one-cycle pulse when a move is rejected by a wall.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: pos=(START_X,START_Y), probe=(0,0), busy=0, blocked=0, state=IDLE, hit accumulator=0.
- Reset asserted mid-check aborts the check, discards the proposed target and returns all outputs to their reset values on the next edge.
- IDLE:
  - frame_tick=1 with a valid direction key: compute the target, latch it, clear the accumulator, go to PROBE with corner index 0.
  - Invalid key, or frame_tick=0: stay in IDLE.
- Target computation (11-bit signed arithmetic, clamped):
  - x is clamped to [0, SCREEN_W-SPRITE_W]; y is clamped to [0, SCREEN_H-SPRITE_H].
  - If the clamped target equals the current position, no probe is issued and the block stays in IDLE (no busy, no blocked).
- PROBE:
  - Issue one corner per cycle in the order TL(tx,ty), TR(tx+W-1,ty), BL(tx,ty+H-1), BR(tx+W-1,ty+H-1).
  - probe_x/probe_y are registered outputs.
- WAIT: hold for LOOKUP_LAT cycles after the last probe so that all four wall_hit samples are captured.
  - wall_hit is sampled exactly LOOKUP_LAT cycles after each probe and OR-ed into the accumulator.
  - The block tracks sample alignment with a shift register of probe-valid bits.
- DECIDE:
  - Accumulator=0: pos <= target.
  - Accumulator=1: pos unchanged, blocked=1 for this cycle only.
  - Return to IDLE.
- busy is high from the cycle after the accepting frame_tick through DECIDE inclusive.
- Latency: with LOOKUP_LAT=1, pos updates 6 cycles after the accepting frame_tick (4 probe + 1 wait + 1 decide).
- frame_tick while busy=1 is ignored (not queued).
- keycode changes during a check have no effect; the latched target is used.
- probe_x/probe_y hold their last value when not probing.

Decomposition:
- Package wall_game_pkg:
  - keycode constants KEY_W/A/S/D.
  - SCREEN_W/SCREEN_H.
  - state enum {IDLE, PROBE, WAIT, DECIDE}.
  - corner index typedef (2-bit).
- One sub-module, wall_probe_seq:
  - Given a latched target and a start pulse, emits the four corner coordinates in order plus a valid bit.
  - Delays that valid bit by LOOKUP_LAT to produce a sample strobe.
- The main FSM, clamping and commit logic stay in wall_move_ctrl.

Test Plan:
- Reset held 2 cycles, then released -> pos=(320,240), busy=0, blocked=0, probe=(0,0).
- frame_tick with keycode=0x07, wall_hit tied 0 -> probes (322,240),(337,240),(322,255),(337,255) on consecutive cycles; pos=(322,240) 6 cycles after tick; blocked stays 0.
- Same move with wall_hit=1 only on the sample for probe (337,240) -> pos stays (320,240), blocked pulses for exactly 1 cycle, busy drops the following cycle.
- Edge clamp: pos_x=1 with keycode=0x04 -> pos_x=0. Then another 0x04 tick -> no probes, busy stays 0, pos unchanged.
- Second frame_tick 2 cycles after the first (busy=1) -> ignored; exactly one move of 2 px occurs.
- Reset asserted during PROBE (corner 2) -> next cycle pos=(320,240), busy=0, no blocked pulse; a subsequent valid tick completes normally.

Source files
------------

// File: rtl/wall_game_pkg.sv
// Shared types and constants for the wall-maze movement path.
// Pure declarations: no latency, no flow control.
package wall_game_pkg;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {IDLE, PROBE, WAIT, DECIDE} state_t;

  typedef logic [1:0] corner_t;
  localparam corner_t CORNER_TL = 2'd0;
  localparam corner_t CORNER_TR = 2'd1;
  localparam corner_t CORNER_BL = 2'd2;
  localparam corner_t CORNER_BR = 2'd3;

  typedef struct packed {
    logic               vld;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
  } move_t;

  // Unknown keycodes yield vld=0 and a zero delta.
  function automatic move_t key_to_move(input logic [7:0] key, input int step);
    move_t m;
    m = '0;
    case (key)
      KEY_W: begin m.vld = 1'b1; m.dy = -11'(step); end
      KEY_S: begin m.vld = 1'b1; m.dy = 11'(step);  end
      KEY_A: begin m.vld = 1'b1; m.dx = -11'(step); end
      KEY_D: begin m.vld = 1'b1; m.dx = 11'(step);  end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wall_probe_seq.sv
// Emits the four sprite-corner probes (TL,TR,BL,BR) one per cycle after start; probe lags start by 1 cycle.
// sample_vld trails each probe by LOOKUP_LAT cycles; no backpressure, start is honoured only when the caller is idle.
module wall_probe_seq
  import wall_game_pkg::*;
#(
  parameter int SPRITE_W   = 16,
  parameter int SPRITE_H   = 16,
  parameter int LOOKUP_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] tx,
  input  logic [9:0] ty,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  output corner_t    corner,
  output logic       sample_vld
);

  logic                  active;
  logic                  probe_vld;
  logic [LOOKUP_LAT-1:0] vld_sr;

  assign sample_vld = vld_sr[LOOKUP_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      active    <= 1'b0;
      corner    <= CORNER_TL;
      probe_x   <= '0;
      probe_y   <= '0;
      probe_vld <= 1'b0;
      vld_sr    <= '0;
    end else begin
      probe_vld <= active;
      // Alignment line: bit LOOKUP_LAT-1 marks the cycle wall_hit belongs to a probe.
      vld_sr    <= (vld_sr << 1) | LOOKUP_LAT'(probe_vld);
      if (start) begin
        active <= 1'b1;
        corner <= CORNER_TL;
      end else if (active) begin
        probe_x <= corner[0] ? tx + 10'(SPRITE_W - 1) : tx;
        probe_y <= corner[1] ? ty + 10'(SPRITE_H - 1) : ty;
        corner  <= corner + 2'd1;
        if (corner == CORNER_BR) active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wall_move_ctrl.sv
// Per-frame sprite mover: clamps the keyed step, probes 4 corners in the wall map, commits if none hit.
// Latency tick->pos = 4 + LOOKUP_LAT + 1 cycles; ticks arriving while busy are dropped, never queued.
module wall_move_ctrl #(
  parameter int SPRITE_W   = 16,
  parameter int SPRITE_H   = 16,
  parameter int STEP       = 2,
  parameter int START_X    = 320,
  parameter int START_Y    = 240,
  parameter int SCREEN_W   = wall_game_pkg::SCREEN_W,
  parameter int SCREEN_H   = wall_game_pkg::SCREEN_H,
  parameter int LOOKUP_LAT = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  input  logic       wall_hit,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       busy,
  output logic       blocked
);
  import wall_game_pkg::*;

  localparam logic signed [10:0] MAX_X  = 11'(SCREEN_W - SPRITE_W);
  localparam logic signed [10:0] MAX_Y  = 11'(SCREEN_H - SPRITE_H);
  localparam int                 WAIT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

  state_t             state;
  logic [9:0]         tgt_x, tgt_y;
  logic               acc;
  logic [WAIT_W-1:0]  wait_cnt;
  move_t              mv;
  logic signed [10:0] nx_raw, ny_raw;
  logic [9:0]         nx, ny;
  logic               accept;
  logic               hit_now;
  logic               seq_start;
  corner_t            corner;
  logic               sample_vld;

  always_comb begin
    mv     = key_to_move(keycode, STEP);
    nx_raw = $signed({1'b0, pos_x}) + mv.dx;
    ny_raw = $signed({1'b0, pos_y}) + mv.dy;
    if (nx_raw < 11'sd0)     nx = '0;
    else if (nx_raw > MAX_X) nx = MAX_X[9:0];
    else                     nx = nx_raw[9:0];
    if (ny_raw < 11'sd0)     ny = '0;
    else if (ny_raw > MAX_Y) ny = MAX_Y[9:0];
    else                     ny = ny_raw[9:0];
    // A clamped step that goes nowhere is not worth a probe.
    accept = (state == IDLE) && frame_tick && mv.vld && ({nx, ny} != {pos_x, pos_y});
  end

  assign hit_now   = sample_vld && wall_hit;
  assign seq_start = accept;

  wall_probe_seq #(
    .SPRITE_W   (SPRITE_W),
    .SPRITE_H   (SPRITE_H),
    .LOOKUP_LAT (LOOKUP_LAT)
  ) u_seq (
    .clk        (Clk),
    .reset      (Reset),
    .start      (seq_start),
    .tx         (tgt_x),
    .ty         (tgt_y),
    .probe_x    (probe_x),
    .probe_y    (probe_y),
    .corner     (corner),
    .sample_vld (sample_vld)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      pos_x    <= 10'(START_X);
      pos_y    <= 10'(START_Y);
      tgt_x    <= '0;
      tgt_y    <= '0;
      acc      <= 1'b0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      blocked  <= 1'b0;
    end else begin
      blocked <= 1'b0;
      if (hit_now) acc <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            tgt_x <= nx;
            tgt_y <= ny;
            acc   <= 1'b0;
            busy  <= 1'b1;
            state <= PROBE;
          end
        end
        PROBE: begin
          if (corner == CORNER_BR) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_W'(LOOKUP_LAT - 1)) state <= DECIDE;
          else                                     wait_cnt <= wait_cnt + 1'b1;
        end
        DECIDE: begin
          // The last corner's sample lands on this very edge, so fold it in directly.
          if (acc || hit_now) begin
            blocked <= 1'b1;
          end else begin
            pos_x <= tgt_x;
            pos_y <= tgt_y;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
